// File: rtl/credit_rx_fifo.sv
// Receiver-side show-ahead FIFO for a credit-based link; returns one credit per pop.
// Optional sticky overflow flag and assertion enabled by CREDIT_RX_ERR_EN.
module credit_rx_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int PTR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 credit_ret,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 err
);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 credit_q;
    logic                 empty;
    logic                 full;
    logic                 pop;
    logic                 wr_en;

    assign empty     = (cnt == '0);
    assign full      = (cnt == CNT_WIDTH'(DEPTH));
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle cannot free room: its credit has not reached the sender.
    assign wr_en     = push && !full;

    assign out_data   = mem[rd_ptr];
    assign count      = cnt;
    assign credit_ret = credit_q;

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            credit_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            cnt      <= cnt + CNT_WIDTH'(wr_en) - CNT_WIDTH'(pop);
            credit_q <= pop;
        end
    end

`ifdef CREDIT_RX_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (push && full) begin
            err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full))
            else $error("credit_rx_fifo: push while full");
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_credit_rx_fifo.sv
// Self-checking bench for credit_rx_fifo: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_credit_rx_fifo;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          push;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          credit_ret;
    logic [CW-1:0] count;
    logic          err;

    int tests;
    int fails;

    logic [W-1:0] q[$];
    bit           exp_credit;
    bit           exp_err;

    credit_rx_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .credit_ret (credit_ret),
        .count      (count),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: drive inputs, let the edge happen, advance the model.
    task automatic step(input bit r, input bit p, input logic [W-1:0] d,
                        input bit rdy);
        bit was_full;
        bit pp;
        rst       = r;
        push      = p;
        in_data   = d;
        out_ready = rdy;
        @(posedge clk);
        if (r) begin
            q.delete();
            exp_credit = 1'b0;
            exp_err    = 1'b0;
        end else begin
            was_full   = (q.size() == D);
            pp         = (q.size() != 0) && rdy;
            exp_credit = pp;
`ifdef CREDIT_RX_ERR_EN
            if (p && was_full) exp_err = 1'b1;
`endif
            if (pp) void'(q.pop_front());
            if (p && !was_full) q.push_back(d);
        end
        #1;
        rst       = 1'b0;
        push      = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 8'h00, 0);
            tests++;
            if (count !== 4'd0 || out_valid !== 1'b0 ||
                credit_ret !== 1'b0 || err !== 1'b0) begin
                fails++;
                $display("FAIL reset_idle cyc %0d got cnt=%0d v=%b cr=%b err=%b exp 0 0 0 0",
                         i, count, out_valid, credit_ret, err);
            end
        end
    endtask

    task automatic test_single_push();
        step(0, 1, 8'hA1, 0);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'hA1 || count !== 4'd1) begin
            fails++;
            $display("FAIL single_push got v=%b d=%h cnt=%0d exp 1 a1 1",
                     out_valid, out_data, count);
        end
        tests++;
        if (credit_ret !== 1'b0) begin
            fails++;
            $display("FAIL single_push_credit got %b exp 0", credit_ret);
        end
    endtask

    task automatic test_pop_credit();
        step(0, 0, 8'h00, 1);
        tests++;
        if (credit_ret !== 1'b1 || count !== 4'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL pop_credit got cr=%b cnt=%0d v=%b exp 1 0 0",
                     credit_ret, count, out_valid);
        end
        step(0, 0, 8'h00, 1);
        tests++;
        if (credit_ret !== 1'b0) begin
            fails++;
            $display("FAIL pop_credit_single got %b exp 0", credit_ret);
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] v;
        for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h10 + i), 0);
        tests++;
        if (count !== 4'd8) begin
            fails++;
            $display("FAIL ovf_fill got cnt=%0d exp 8", count);
        end
        step(0, 1, 8'hFF, 0);
        tests++;
        if (count !== 4'd8 || err !== exp_err) begin
            fails++;
            $display("FAIL ovf_drop got cnt=%0d err=%b exp 8 %b",
                     count, err, exp_err);
        end
        // Overflow push with a simultaneous pop must still be dropped.
        tests++;
        if (out_data !== 8'h10) begin
            fails++;
            $display("FAIL ovf_head got %h exp 10", out_data);
        end
        step(0, 1, 8'hEE, 1);
        tests++;
        if (count !== 4'd7 || credit_ret !== 1'b1) begin
            fails++;
            $display("FAIL ovf_pop_drop got cnt=%0d cr=%b exp 7 1",
                     count, credit_ret);
        end
        for (int i = 1; i < 8; i++) begin
            v = 8'(8'h10 + i);
            tests++;
            if (out_valid !== 1'b1 || out_data !== v) begin
                fails++;
                $display("FAIL ovf_drain %0d got v=%b d=%h exp 1 %h",
                         i, out_valid, out_data, v);
            end
            step(0, 0, 8'h00, 1);
            tests++;
            if (credit_ret !== 1'b1) begin
                fails++;
                $display("FAIL ovf_credit %0d got %b exp 1", i, credit_ret);
            end
        end
        tests++;
        if (count !== 4'd0 || err !== exp_err) begin
            fails++;
            $display("FAIL ovf_end got cnt=%0d err=%b exp 0 %b",
                     count, err, exp_err);
        end
        step(0, 0, 8'h00, 0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h40 + i), 0);
        tests++;
        if (count !== 4'd4) begin
            fails++;
            $display("FAIL rstmid_fill got cnt=%0d exp 4", count);
        end
        step(1, 0, 8'h00, 1);
        tests++;
        if (count !== 4'd0 || out_valid !== 1'b0 ||
            credit_ret !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL rstmid got cnt=%0d v=%b cr=%b err=%b exp 0 0 0 0",
                     count, out_valid, credit_ret, err);
        end
        step(0, 0, 8'h00, 1);
        tests++;
        if (credit_ret !== 1'b0 || count !== 4'd0) begin
            fails++;
            $display("FAIL rstmid_after got cr=%b cnt=%0d exp 0 0",
                     credit_ret, count);
        end
    endtask

    task automatic test_wrap();
        int pulses;
        int n;
        logic [W-1:0] v;
        pulses = 0;
        for (int ph = 0; ph < 2; ph++) begin
            n = (ph == 0) ? 5 : 8;
            for (int i = 0; i < n; i++) begin
                step(0, 1, 8'($urandom), 0);
                if (credit_ret === 1'b1) pulses++;
            end
            for (int i = 0; i < n; i++) begin
                v = q[0];
                tests++;
                if (out_valid !== 1'b1 || out_data !== v) begin
                    fails++;
                    $display("FAIL wrap_order ph%0d %0d got v=%b d=%h exp 1 %h",
                             ph, i, out_valid, out_data, v);
                end
                step(0, 0, 8'h00, 1);
                if (credit_ret === 1'b1) pulses++;
            end
        end
        step(0, 0, 8'h00, 0);
        if (credit_ret === 1'b1) pulses++;
        tests++;
        if (pulses != 13 || count !== 4'd0) begin
            fails++;
            $display("FAIL wrap_credits got pulses=%0d cnt=%0d exp 13 0",
                     pulses, count);
        end
    endtask

    task automatic test_simul();
        logic [W-1:0] exp_seq [4];
        exp_seq[0] = 8'h01;
        exp_seq[1] = 8'h02;
        exp_seq[2] = 8'h03;
        exp_seq[3] = 8'h33;
        for (int i = 0; i < 3; i++) step(0, 1, exp_seq[i], 0);
        tests++;
        if (out_data !== 8'h01) begin
            fails++;
            $display("FAIL simul_head got %h exp 01", out_data);
        end
        step(0, 1, 8'h33, 1);
        tests++;
        if (count !== 4'd3 || credit_ret !== 1'b1) begin
            fails++;
            $display("FAIL simul_count got cnt=%0d cr=%b exp 3 1",
                     count, credit_ret);
        end
        for (int i = 1; i < 4; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== exp_seq[i]) begin
                fails++;
                $display("FAIL simul_order %0d got v=%b d=%h exp 1 %h",
                         i, out_valid, out_data, exp_seq[i]);
            end
            step(0, 0, 8'h00, 1);
        end
        tests++;
        if (count !== 4'd0) begin
            fails++;
            $display("FAIL simul_end got cnt=%0d exp 0", count);
        end
    endtask

    // Sender with a credit counter pushes only when it holds a credit.
    task automatic test_random();
        int credits;
        bit p;
        bit rdy;
        credits = D - q.size() - int'(exp_credit);
        for (int i = 0; i < 400; i++) begin
            tests++;
            if (count !== CW'(q.size()) || out_valid !== (q.size() != 0) ||
                credit_ret !== exp_credit || err !== exp_err) begin
                fails++;
                $display("FAIL rand_state %0d got cnt=%0d v=%b cr=%b err=%b exp %0d %b %b %b",
                         i, count, out_valid, credit_ret, err,
                         q.size(), q.size() != 0, exp_credit, exp_err);
            end
            if (q.size() != 0) begin
                tests++;
                if (out_data !== q[0]) begin
                    fails++;
                    $display("FAIL rand_data %0d got %h exp %h", i, out_data, q[0]);
                end
            end
            p   = (credits > 0) && ($urandom_range(0, 99) < 60);
            rdy = ($urandom_range(0, 99) < 45);
            credits = credits - int'(p) + int'(exp_credit);
            step(0, p, 8'($urandom), rdy);
        end
        tests++;
        if (credits + q.size() + int'(exp_credit) != D) begin
            fails++;
            $display("FAIL rand_invariant got %0d exp %0d",
                     credits + q.size() + int'(exp_credit), D);
        end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        exp_credit = 1'b0;
        exp_err    = 1'b0;
        rst        = 1'b1;
        push       = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        test_reset();
        test_single_push();
        test_pop_credit();
        test_overflow();
        test_reset_mid();
        test_wrap();
        test_simul();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
